core_mem_port: RTL and testbench

CORE_MEM_PORT -- requirements
Module: core_mem_port

---
 rtl/core_mem_port.sv | 151 +++++++++++++++
 tb/tb_core_mem_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_port
// Description : Core load/store port onto one requester slot of a shared-RAM
//               arbiter. Optional macro CORE_MEM_PORT_TIMEOUT_EN adds a
//               request timeout that aborts the command with rsp_err = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_port #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             request,
    input  logic             response,
    output logic             wren_core,
    output logic [WIDTH-1:0] address_out,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_request;
    logic               r_wren;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_rdata;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("core_mem_port: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef CORE_MEM_PORT_TIMEOUT_EN
    localparam int                 c_CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_rsp_err;
    logic               w_timeout;

    // Fires on the REQ cycle whose idle edge would bring the count to TIMEOUT_CYCLES;
    // a grant in that same cycle takes priority.
    assign w_timeout = (r_tmo_cnt == c_TIMEOUT_LAST) && !response;
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_request   <= 1'b0;
            r_wren      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef CORE_MEM_PORT_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state   <= S_REQ;
                        r_request <= 1'b1;
                        r_wren    <= cmd_write;
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
`ifdef CORE_MEM_PORT_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (response) begin
                        // r_wren doubles as the latched store/load flag while in REQ
                        if (r_wren) begin
                            r_state     <= S_IDLE;
                            r_request   <= 1'b0;
                            r_wren      <= 1'b0;
                            r_rsp_valid <= 1'b1;
`ifdef CORE_MEM_PORT_TIMEOUT_EN
                            r_rsp_err   <= 1'b0;
`endif
                        end else begin
                            r_state <= S_RDATA;
                            r_wren  <= 1'b0;
                        end
`ifdef CORE_MEM_PORT_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_request   <= 1'b0;
                        r_wren      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_CNT_ONE;
`endif
                    end
                end
                S_RDATA: begin
                    // The arbiter's RAM output is registered: read data arrives one edge after grant
                    r_state     <= S_IDLE;
                    r_request   <= 1'b0;
                    r_wren      <= 1'b0;
                    r_rsp_rdata <= data_in;
                    r_rsp_valid <= 1'b1;
`ifdef CORE_MEM_PORT_TIMEOUT_EN
                    r_rsp_err   <= 1'b0;
`endif
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_request <= 1'b0;
                    r_wren    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign request     = r_request;
    assign wren_core   = r_wren;
    assign address_out = r_addr;
    assign data_out    = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_port
// Description : Self-checking bench for core_mem_port; the bench plays the
//               arbiter + registered RAM and keeps a command-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_port;

    localparam int WIDTH = 32;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_write = 1'b0;
    logic [WIDTH-1:0] cmd_addr = '0;
    logic [WIDTH-1:0] cmd_wdata = '0;
    logic             response = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             cmd_ready, rsp_valid, rsp_err, request, wren_core;
    logic [WIDTH-1:0] rsp_rdata, address_out, data_out;

    int n_vec = 0;
    int n_err = 0;
    int rsp_count = 0;

    logic [WIDTH-1:0] ref_mem [16];
    logic [WIDTH-1:0] bus_mem [16];
    logic [WIDTH-1:0] exp_rdata = '0;

    core_mem_port #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .request(request), .response(response), .wren_core(wren_core),
        .address_out(address_out), .data_out(data_out), .data_in(data_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arbiter side of a grant: RAM writes on grant, read data appears after the edge.
    task automatic grant_edge();
        logic [WIDTH-1:0] rd;
        response = 1'b1;
        if (wren_core === 1'b1) bus_mem[address_out[3:0]] = data_out;
        rd = bus_mem[address_out[3:0]];
        @(posedge clk); #1;
        response = 1'b0;
        data_in  = rd;
    endtask

    // Full command; entered at posedge+1 with the port idle, leaves one idle cycle after rsp.
    task automatic do_cmd(input logic w, input int idx, input logic [WIDTH-1:0] d, input int delay);
        logic [WIDTH-1:0] a;
        int pre;
        a   = WIDTH'(idx);
        pre = rsp_count;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        n_vec++; if ({request, wren_core, cmd_ready, address_out, data_out} !== {1'b1, w, 1'b0, a, d}) begin
            n_err++; $display("FAIL req_drive: got req=%b wr=%b rdy=%b a=%h d=%h expected req=1 wr=%b rdy=0 a=%h d=%h",
                              request, wren_core, cmd_ready, address_out, data_out, w, a, d);
        end
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            n_vec++; if ({request, rsp_valid, wren_core, address_out} !== {1'b1, 1'b0, w, a}) begin
                n_err++; $display("FAIL req_wait: cycle %0d got req=%b rv=%b wr=%b a=%h expected 1 0 %b %h",
                                  i, request, rsp_valid, wren_core, address_out, w, a);
            end
        end
        grant_edge();
        if (w) begin
            ref_mem[idx] = d;
            n_vec++; if ({rsp_valid, rsp_err, request, wren_core, cmd_ready} !== 5'b10001) begin
                n_err++; $display("FAIL store_rsp: got rv=%b err=%b req=%b wr=%b rdy=%b expected 1 0 0 0 1",
                                  rsp_valid, rsp_err, request, wren_core, cmd_ready);
            end
            n_vec++; if (rsp_rdata !== exp_rdata) begin
                n_err++; $display("FAIL store_rdata_hold: got %h expected %h", rsp_rdata, exp_rdata);
            end
        end else begin
            n_vec++; if ({rsp_valid, request, wren_core} !== 3'b010) begin
                n_err++; $display("FAIL load_rdata_state: got rv=%b req=%b wr=%b expected 0 1 0", rsp_valid, request, wren_core);
            end
            @(posedge clk); #1;
            data_in   = $urandom;
            exp_rdata = ref_mem[idx];
            n_vec++; if ({rsp_valid, rsp_err, request, cmd_ready} !== 4'b1001) begin
                n_err++; $display("FAIL load_rsp: got rv=%b err=%b req=%b rdy=%b expected 1 0 0 1", rsp_valid, rsp_err, request, cmd_ready);
            end
            n_vec++; if (rsp_rdata !== exp_rdata) begin
                n_err++; $display("FAIL load_rdata: addr %0d got %h expected %h", idx, rsp_rdata, exp_rdata);
            end
        end
        @(posedge clk); #1;
        n_vec++; if ({rsp_valid, request} !== 2'b00 || rsp_count - pre !== 1) begin
            n_err++; $display("FAIL rsp_single: got rv=%b req=%b pulses=%0d expected 0 0 1", rsp_valid, request, rsp_count - pre);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; response = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_vec++; if ({cmd_ready, request, wren_core, rsp_valid, rsp_err} !== 5'b10000) begin
            n_err++; $display("FAIL reset_ctrl: got rdy/req/wr/rv/err=%b expected 10000",
                              {cmd_ready, request, wren_core, rsp_valid, rsp_err});
        end
        n_vec++; if ({rsp_rdata, address_out, data_out} !== {3*WIDTH{1'b0}}) begin
            n_err++; $display("FAIL reset_data: got rd=%h a=%h d=%h expected all 0", rsp_rdata, address_out, data_out);
        end
        cmd_valid = 1'b0; response = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({cmd_ready, request, rsp_valid} !== 3'b100) begin
            n_err++; $display("FAIL reset_release: got rdy/req/rv=%b expected 100", {cmd_ready, request, rsp_valid});
        end
    endtask

    task automatic test_store_load();
        do_cmd(1'b1, 3, 32'd9, 2);
        n_vec++; if (bus_mem[3] !== 32'd9) begin n_err++; $display("FAIL ram3_written: got %h expected 9", bus_mem[3]); end
        do_cmd(1'b0, 3, '0, 2);
    endtask

    task automatic test_idle_response();
        int pre;
        pre = rsp_count;
        for (int i = 0; i < 3; i++) begin
            response = 1'b1;
            @(posedge clk); #1;
            n_vec++; if ({request, rsp_valid, cmd_ready} !== 3'b001) begin
                n_err++; $display("FAIL idle_response: got req/rv/rdy=%b expected 001", {request, rsp_valid, cmd_ready});
            end
        end
        response = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (rsp_count !== pre) begin n_err++; $display("FAIL idle_no_rsp: got %0d pulses expected 0", rsp_count - pre); end
    endtask

    task automatic test_back_to_back();
        int pre;
        logic [WIDTH-1:0] d1, d2;
        pre = rsp_count; d1 = $urandom; d2 = $urandom;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd5; cmd_wdata = d1;
        @(posedge clk); #1;
        cmd_addr = 32'd6; cmd_wdata = d2;
        repeat (2) begin
            @(posedge clk); #1;
            n_vec++; if ({cmd_ready, request, address_out} !== {1'b0, 1'b1, 32'd5}) begin
                n_err++; $display("FAIL b2b_busy: got rdy=%b req=%b a=%h expected 0 1 5", cmd_ready, request, address_out);
            end
        end
        grant_edge();
        ref_mem[5] = d1;
        n_vec++; if ({rsp_valid, cmd_ready} !== 2'b11) begin
            n_err++; $display("FAIL b2b_first_rsp: got rv=%b rdy=%b expected 1 1", rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_vec++; if ({request, wren_core, rsp_valid, address_out, data_out} !== {3'b110, 32'd6, d2}) begin
            n_err++; $display("FAIL b2b_second_accept: got req=%b wr=%b rv=%b a=%h d=%h expected 1 1 0 6 %h",
                              request, wren_core, rsp_valid, address_out, data_out, d2);
        end
        @(posedge clk); #1;
        grant_edge();
        ref_mem[6] = d2;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_rsp: got %b expected 1", rsp_valid); end
        @(posedge clk); #1;
        n_vec++; if (rsp_count - pre !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", rsp_count - pre); end
        n_vec++; if ({bus_mem[5], bus_mem[6]} !== {d1, d2}) begin
            n_err++; $display("FAIL b2b_ram: got %h %h expected %h %h", bus_mem[5], bus_mem[6], d1, d2);
        end
    endtask

    task automatic test_reset_mid_load();
        int pre;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3; cmd_wdata = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        grant_edge();
        pre = rsp_count;
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if ({request, rsp_valid, cmd_ready, rsp_rdata} !== {3'b001, 32'd0}) begin
            n_err++; $display("FAIL reset_mid_load: got req=%b rv=%b rdy=%b rd=%h expected 0 0 1 0", request, rsp_valid, cmd_ready, rsp_rdata);
        end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; exp_rdata = '0;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (rsp_count !== pre || request !== 1'b0) begin
            n_err++; $display("FAIL reset_drop: got pulses=%0d req=%b expected 0 0", rsp_count - pre, request);
        end
        do_cmd(1'b0, 3, '0, 1);
    endtask

`ifdef CORE_MEM_PORT_TIMEOUT_EN
    task automatic test_timeout();
        do_cmd(1'b0, 7, '0, 0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd2; cmd_wdata = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            @(posedge clk); #1;
            n_vec++; if ({request, rsp_valid} !== 2'b10) begin
                n_err++; $display("FAIL timeout_wait: cycle %0d got req=%b rv=%b expected 1 0", i, request, rsp_valid);
            end
        end
        @(posedge clk); #1;
        exp_rdata = '0;
        n_vec++; if ({request, rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {4'b0111, 32'd0}) begin
            n_err++; $display("FAIL timeout_abort: got req=%b rv=%b err=%b rdy=%b rd=%h expected 0 1 1 1 0",
                              request, rsp_valid, rsp_err, cmd_ready, rsp_rdata);
        end
        @(posedge clk); #1;
        do_cmd(1'b0, 2, '0, TMO - 1);
        do_cmd(1'b1, 2, $urandom, TMO - 1);
    endtask
`else
    task automatic test_timeout();
        do_cmd(1'b0, 2, '0, 40);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_cmd(1'($urandom), int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, TMO - 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        test_reset();
        test_store_load();
        test_idle_response();
        test_back_to_back();
        test_reset_mid_load();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
